// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit:
// funct3 op encodings, FSM state type and op-classification helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } md_state_e;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV)  || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement negate (md_negate).
// Ports: value (W), neg (1) -> result = neg ? -value : value.
module md_negate
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit (shift-add / restoring).
// Ports: clk, rst, start, op, a, b, flush -> busy, stall_req, done, result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state, state_d;

  logic [2:0]      op_q;
  logic [XLEN-1:0] mcand;
  logic [W2-1:0]   acc;
  logic            res_sign;
  logic [CNT_W-1:0] cnt;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            accept, last;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] spec_res;

  assign a_neg = is_signed_a(op) & a[XLEN-1];
  assign b_neg = is_signed_b(op) & b[XLEN-1];

  md_negate #(.W(XLEN)) u_neg_a (
    .value  (a),
    .neg    (a_neg),
    .result (mag_a)
  );

  md_negate #(.W(XLEN)) u_neg_b (
    .value  (b),
    .neg    (b_neg),
    .result (mag_b)
  );

  assign busy      = (state == MUL) || (state == DIV);
  assign done      = (state == DONE);
  assign stall_req = busy | (start & ~done);

  assign accept = start & ~flush &
                  ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CNT_W'(XLEN - 1));

  // Divide-by-zero and MIN/-1 overflow bypass the iteration.
  assign b_zero  = (b == '0);
  assign ovf     = is_signed_b(op) & is_div(op) &
                   (a == MIN_NEG) & (b == '1);
  assign special = is_div(op) & (b_zero | ovf);

  always_comb begin
    spec_res = '0;
    if (b_zero)
      spec_res = is_rem(op) ? a : '1;
    else
      spec_res = is_rem(op) ? '0 : a;
  end

  // Shift-add: acc holds {partial product high, remaining multiplier}.
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc[W2-1:XLEN]} +
                    (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: acc holds {partial remainder, dividend/quotient}.
  logic [XLEN:0]   div_rs;
  logic            div_ge;
  logic [XLEN:0]   div_r;
  logic [W2-1:0]   div_next;

  assign div_rs   = {acc[W2-1:XLEN], acc[XLEN-1]};
  assign div_ge   = (div_rs >= {1'b0, mcand});
  assign div_r    = div_ge ? (div_rs - {1'b0, mcand}) : div_rs;
  assign div_next = {div_r[XLEN-1:0], acc[XLEN-2:0], div_ge};

  logic [W2-1:0]   step_next;
  logic [W2-1:0]   fix_in, fixed;
  logic [XLEN-1:0] final_res;

  assign step_next = (state == MUL) ? mul_next : div_next;

  // One wide negator covers both the full product and the
  // zero-extended quotient/remainder; low bits are unaffected by width.
  always_comb begin
    fix_in = '0;
    if (state == MUL)
      fix_in = mul_next;
    else if (is_rem(op_q))
      fix_in = {{XLEN{1'b0}}, div_next[W2-1:XLEN]};
    else
      fix_in = {{XLEN{1'b0}}, div_next[XLEN-1:0]};
  end

  md_negate #(.W(W2)) u_fix (
    .value  (fix_in),
    .neg    (res_sign),
    .result (fixed)
  );

  assign final_res = ((state == MUL) && (op_q != MD_MUL)) ?
                     fixed[W2-1:XLEN] : fixed[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (special)
            state_d = DONE;
          else if (is_div(op))
            state_d = DIV;
          else
            state_d = MUL;
        end
      end
      MUL, DIV: begin
        if (last)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      mcand    <= '0;
      acc      <= '0;
      res_sign <= 1'b0;
      cnt      <= '0;
      result   <= '0;
    end else if (accept) begin
      op_q     <= op;
      mcand    <= is_div(op) ? mag_b : mag_a;
      acc      <= {{XLEN{1'b0}}, is_div(op) ? mag_a : mag_b};
      res_sign <= is_rem(op) ? a_neg : (a_neg ^ b_neg);
      cnt      <= '0;
      if (special)
        result <= spec_res;
    end else if (busy && !flush) begin
      acc <= step_next;
      cnt <= cnt + CNT_W'(1);
      if (last)
        result <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit (XLEN=32).
// Expected results/latencies are queued at issue and checked on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, stall_req, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [31:0] last_res = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] x, y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p = '0;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o,
                                input logic [31:0] x, y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 &&
        y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check(mon_e.tag, result, mon_e.res);
        check({mon_e.tag, "_lat"}, 32'(cyc - mon_e.cyc), 32'(mon_e.lat));
        check({mon_e.tag, "_stall"}, 32'(stall_req & ~start), 32'd0);
        last_res = mon_e.res;
      end
    end
  end

  task automatic push_exp(input logic [31:0] exp, input int lat,
                          input string tag);
    exp_t e;
    e.res = exp;
    e.cyc = cyc;
    e.lat = lat;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, y,
                       input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    push_exp(exp, lat_of(o, x, y), tag);
    #1 check({tag, "_req"}, 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  int dcount;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);

    issue(MD_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    drain();
    issue(MD_MULH,   32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh");
    drain();
    issue(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    drain();
    issue(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    drain();
    issue(MD_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, "div");
    drain();
    issue(MD_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, "rem");
    drain();
    issue(MD_DIVU, 32'd100, 32'd7, 32'd14, "divu");
    drain();
    issue(MD_REMU, 32'd100, 32'd7, 32'd2, "remu");
    drain();
    issue(MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, "div0");
    drain();
    issue(MD_REM,  32'd5, 32'd0, 32'd5, "rem0");
    drain();
    issue(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    drain();
    issue(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
    drain();

    // start during MUL must be ignored
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_ign");
    repeat (3) @(posedge clk);
    #1;
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    #1 check("ign_busy", 32'(busy), 32'd1);
    check("ign_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // flush mid-divide: no done, result held
    @(posedge clk); #1;
    op = MD_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, last_res);
    check("flush_stall", 32'(stall_req), 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("flush_nodone", 32'(dcount), 32'd0);
    check("flush_result2", result, last_res);

    // back-to-back: DIVU issued in the MULHU done cycle
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "b2b_mulhu");
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    check("b2b_seen_done", 32'(done), 32'd1);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    push_exp(32'd14, 33, "b2b_divu");
    #1 check("b2b_stall_done", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    drain();

    // random operands against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(r_op, r_a, r_b, model(r_op, r_a, r_b), "rnd");
      drain();
    end

    // asynchronous reset mid-multiply
    issue(MD_MUL, 32'd3, 32'd5, 32'd15, "mul_rst");
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_stall", 32'(stall_req), 32'd0);
    q.delete();
    @(posedge clk); #2 rst = 1'b0;

    issue(MD_DIVU, 32'd100, 32'd7, 32'd14, "post_rst");
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
